// File: rtl/onchip_mem_stream_reader_pkg.sv
// Shared types and default widths for the on-chip memory stream reader.
// No ports: holds the FSM state enum, default widths and the checksum lane width.
package onchip_mem_reader_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 128;
    localparam int LANE_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/onchip_mem_stream_reader_if.sv
// Bus bundle between the reader and its environment.
// It carries the Avalon-MM read port toward the RAM (mem_*) and the
// Avalon-ST output stream (st_*). The master modport is the reader side,
// and the slave modport is the RAM/consumer side.
interface onchip_mem_stream_reader_if #(
    parameter int ADDR_W = onchip_mem_reader_pkg::DEF_ADDR_W,
    parameter int DATA_W = onchip_mem_reader_pkg::DEF_DATA_W
);

    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;

    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_ready;
    logic                st_sop;
    logic                st_eop;

    modport master (
        output mem_address, mem_chipselect, mem_write,
        output mem_byteenable, mem_writedata, mem_clken,
        input  mem_readdata,
        output st_data, st_valid, st_sop, st_eop,
        input  st_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write,
        input  mem_byteenable, mem_writedata, mem_clken,
        output mem_readdata,
        input  st_data, st_valid, st_sop, st_eop,
        output st_ready
    );

endinterface

// File: rtl/onchip_mem_stream_reader_fifo.sv
// First-word-fall-through FIFO with an occupancy count output.
// Ports: clk, reset_n (async active-low), wr_en/wr_data, rd_en, rd_data
// (the head word), empty, and count (0..DEPTH). DEPTH must be a power of two.
module mem_reader_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            // A write and a read in the same cycle leave the count unchanged.
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that streams a contiguous run of RAM words out on Avalon-ST.
// Ports: clk, reset_n, start/base_addr/num_words, busy, done, bus (master
// modport of mem_* and st_*). With MEM_READER_CHECKSUM_EN it also has a
// 32-bit checksum output.
module onchip_mem_stream_reader
    import onchip_mem_reader_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
`ifdef MEM_READER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    onchip_mem_stream_reader_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH);

    state_t                  state, state_d;
    logic                    issue;
    logic                    credit;
    logic [7:0]              in_flight;
    logic                    cs_q;
    logic [ADDR_W-1:0]       addr_out;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W-1:0]       issue_addr;
    logic [ADDR_W:0]         issue_left;
    logic [ADDR_W:0]         beats_left;
    logic                    first_q;
    logic [READ_LATENCY-1:0] vld_sr;
    logic [CW:0]             fifo_count;
    logic                    fifo_empty;
    logic [DATA_W-1:0]       fifo_rd;
    logic [DATA_W-1:0]       st_data;
    logic                    st_valid;
    logic                    pop;

    // Reads that are on the bus now or still in the slave pipeline.
    always_comb begin
        in_flight = 8'(cs_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + 8'(vld_sr[i]);
        end
    end

    assign credit = (in_flight + 8'(fifo_count)) < 8'(FIFO_DEPTH);

    // The first read goes out on the start edge itself, from base_addr.
    assign issue_addr = (state == IDLE) ? base_addr : addr_q;

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    issue   = (num_words != '0);
                    state_d = issue ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                issue = credit && (issue_left != '0);
                if (issue_left == '0 ||
                    (issue && issue_left == (ADDR_W+1)'(1)))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (beats_left == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cs_q       <= 1'b0;
            addr_out   <= '0;
            addr_q     <= '0;
            issue_left <= '0;
            beats_left <= '0;
            first_q    <= 1'b0;
            vld_sr     <= '0;
        end else begin
            state  <= state_d;
            cs_q   <= issue;
            vld_sr <= (vld_sr << 1) | READ_LATENCY'(cs_q);
            if (issue) begin
                addr_out <= issue_addr;
                addr_q   <= issue_addr + 1'b1;
            end
            if (state == IDLE && start) begin
                issue_left <= num_words - (ADDR_W+1)'(issue);
                beats_left <= num_words;
                first_q    <= 1'b1;
            end else begin
                if (issue) issue_left <= issue_left - 1'b1;
                if (pop) begin
                    beats_left <= beats_left - 1'b1;
                    first_q    <= 1'b0;
                end
            end
        end
    end

    mem_reader_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (vld_sr[READ_LATENCY-1]),
        .wr_data (bus.mem_readdata),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign st_valid = !fifo_empty;
    // Gate the head word so the payload reads zero whenever nothing is offered.
    assign st_data  = st_valid ? fifo_rd : '0;
    assign pop      = st_valid && bus.st_ready;

    assign busy = (state == ISSUE) || (state == DRAIN);
    assign done = (state == DONE);

    assign bus.mem_address    = addr_out;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = '1;
    assign bus.mem_writedata  = '0;
    assign bus.mem_clken      = 1'b1;
    assign bus.st_data        = st_data;
    assign bus.st_valid       = st_valid;
    assign bus.st_sop         = st_valid && first_q;
    assign bus.st_eop         = st_valid && (beats_left == (ADDR_W+1)'(1));

`ifdef MEM_READER_CHECKSUM_EN
    logic [LANE_W-1:0] lane_sum;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < DATA_W / LANE_W; i++) begin
            lane_sum = lane_sum + st_data[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  checksum <= '0;
        else if (state == IDLE && start) checksum <= '0;
        else if (pop)                  checksum <= checksum + lane_sum;
    end
`endif

endmodule

// File: doc/onchip_mem_stream_reader.md
Name: onchip_mem_stream_reader

Overview:
- Avalon-MM read master for the 128-bit single-port on-chip memory slave.
  - Slave interface: 13-bit word address, 16-bit byteenable, chipselect/write/clken, fixed read latency.
- On a start command, reads a contiguous run of words and presents them as an Avalon-ST stream with valid/ready backpressure.
- Sits between the on-chip RAM and downstream streaming consumers. This is the master end of the RAM's s1 port.

Parameters:
- ADDR_W, 13, word address width; matches the slave depth of 8192.
- DATA_W, 128, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from address issue to valid mem_readdata; legal range 1..4.
- FIFO_DEPTH, 4, output buffer depth in words; must be >= READ_LATENCY+1 and a power of two.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, latched on start.
- num_words  in  ADDR_W+1  word count, 0..8192, latched on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the last word has left the stream.
- mem_address  out  ADDR_W  slave word address.
- mem_chipselect  out  1  read request qualifier.
- mem_write  out  1  tied 0.
- mem_byteenable  out  DATA_W/8  tied all-ones.
- mem_writedata  out  DATA_W  tied 0.
- mem_clken  out  1  tied 1.
- mem_readdata  in  DATA_W  slave read data.
- st_data  out  DATA_W  stream payload.
- st_valid  out  1  payload valid.
- st_ready  in  1  consumer ready.
- st_sop  out  1  first word of the run.
- st_eop  out  1  last word of the run.

Behaviour:
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, st_valid=0, st_sop=0, st_eop=0, st_data=0. Reset also clears the FIFO, the in-flight pipeline and all counters.
- State machine (IDLE, ISSUE, DRAIN, DONE):
  - IDLE: on start, latch base_addr and num_words.
    - num_words==0: go to DONE; no memory access and no stream beats.
    - Otherwise go to ISSUE.
    - start in any other state is ignored.
  - ISSUE: issue one read per cycle (mem_chipselect=1 with a registered mem_address) whenever credit exists.
    - credit = in_flight + fifo_count < FIFO_DEPTH.
    - Go to DRAIN after the last read is issued.
  - DRAIN: no issue. Wait until in_flight==0, the FIFO is empty and the final beat has handshaken. Then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy is low in IDLE and DONE.
- Issue and capture:
  - A valid-bit shift register of length READ_LATENCY tracks issued reads.
  - When the tap emerges, mem_readdata is written into the FIFO.
  - The credit rule guarantees the FIFO never overflows; no read is ever lost or stalled in the slave.
- Address arithmetic:
  - Word i is read from (base_addr + i) mod 2^ADDR_W.
  - Crossing address 8191 wraps to 0 silently.
  - An internal remaining-word counter of ADDR_W+1 bits handles num_words=8192.
- Stream:
  - A beat transfers when st_valid && st_ready.
  - While st_valid=1 and st_ready=0, st_data, st_sop and st_eop hold stable.
  - The FIFO is first-word-fall-through. With st_ready held high, the first beat appears READ_LATENCY+1 cycles after start, then one beat per cycle.
  - st_sop is set on beat 0 and st_eop on beat num_words-1. For num_words=1 both are set on the same beat.
- Simultaneous FIFO write and read in one cycle keeps fifo_count unchanged. This is legal even when the FIFO is full.
- reset_n asserted mid-run aborts immediately with no done pulse. The state after deassertion equals the post-reset state.

Optional Feature:
- Macro: MEM_READER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0].
  - checksum is the modulo-2^32 sum of all 32-bit lanes of every word accepted on the stream during the run.
  - It is cleared on start and valid (stable) from the done pulse until the next start.
  - Reset value is 0.
- Undefined: the port and adder logic are absent; behaviour is otherwise identical.

Decomposition:
- Package onchip_mem_reader_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - default widths (ADDR_W=13, DATA_W=128);
  - the LANE_W=32 constant for the checksum.
- One sub-module, mem_reader_fifo: parameterised FWFT FIFO with count output, async active-low reset.

Test Plan:
- start, base_addr=0x0010, num_words=4, st_ready=1, RAM preloaded with word k = k:
  - mem_address sequence is 0x10..0x13 on consecutive cycles;
  - stream carries 0x10..0x13, sop on beat 0, eop on beat 3;
  - done pulses once.
- base_addr=0x1FFE, num_words=4: addresses are 0x1FFE, 0x1FFF, 0x0000, 0x0001; data follows in that order.
- num_words=0: done pulses 1 cycle after start; mem_chipselect and st_valid never assert.
- num_words=16 with st_ready=0 for 20 cycles, then 1:
  - chipselect count stops at FIFO_DEPTH outstanding plus buffered reads;
  - no words are lost or duplicated; all 16 beats arrive in order;
  - st_data stays stable during the stall.
- num_words=8192, random st_ready at 50%: exactly 8192 beats; checksum (if enabled) equals the reference lane sum.
- reset_n pulsed low mid-run at beat 5: all outputs return to reset values; no done pulse; a subsequent start with num_words=2 completes normally.
